// File: rtl/parallel_unloader_pkg.sv
// Shared constants, FSM encoding and length clamp for the byte-wise loader/unloader pair.
package parallel_unloader_pkg;

  localparam int PU_NUM_BYTES = 15;
  localparam int PU_IDX_W     = 4;
  localparam int BYTE_W       = 8;
  localparam int WORD_W       = BYTE_W * PU_NUM_BYTES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Requested byte count saturates at the word size.
  function automatic int clamp_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/byte_lane_mux.sv
// Selects byte idx_i of the shadow word; out-of-range indices read as zero.
module byte_lane_mux
  import parallel_unloader_pkg::*;
#(
  parameter int NUM_BYTES = PU_NUM_BYTES,
  parameter int IDX_W     = PU_IDX_W
) (
  input  logic [BYTE_W*NUM_BYTES-1:0] shadow_i,
  input  logic [IDX_W-1:0]            idx_i,
  output logic [BYTE_W-1:0]           data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (idx_i == IDX_W'(i)) data_o = shadow_i[BYTE_W*i +: BYTE_W];
    end
  end

endmodule

// File: rtl/parallel_unloader.sv
// Shadows a wide word on start and streams it LSB byte first with its byte index.
// First byte is valid the cycle after start; a byte holds stable while data_ready is low.
module parallel_unloader
  import parallel_unloader_pkg::*;
#(
  parameter int NUM_BYTES = PU_NUM_BYTES,
  parameter int IDX_W     = PU_IDX_W
) (
  input  logic                        mclk,
  input  logic                        reset,
  input  logic [BYTE_W*NUM_BYTES-1:0] bus_in,
  input  logic                        start,
  input  logic [IDX_W-1:0]            len,
  output logic [BYTE_W-1:0]           data_out,
  output logic                        data_valid,
  input  logic                        data_ready,
  output logic [IDX_W-1:0]            byte_idx,
  output logic                        busy,
  output logic                        done
);

  state_e                      state_q, state_d;
  logic [BYTE_W*NUM_BYTES-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [IDX_W-1:0]            cnt_q, cnt_d;
  logic [BYTE_W-1:0]           lane_byte;

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d = bus_in;
          cnt_d    = IDX_W'(clamp_len(int'(len), NUM_BYTES));
          idx_d    = '0;
          state_d  = (cnt_d != '0) ? SEND : FIN;
        end
      end
      SEND: begin
        if (data_ready) begin
          if (idx_q == cnt_q - 1'b1) state_d = FIN;
          else                       idx_d   = idx_q + 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  byte_lane_mux #(
    .NUM_BYTES (NUM_BYTES),
    .IDX_W     (IDX_W)
  ) u_byte_lane_mux (
    .shadow_i (shadow_q),
    .idx_i    (idx_q),
    .data_o   (lane_byte)
  );

  assign data_valid = (state_q == SEND);
  assign done       = (state_q == FIN);
  assign data_out   = data_valid ? lane_byte : '0;
  assign byte_idx   = data_valid ? idx_q : '0;
  // busy covers the accepting cycle too; the reset term drops it asynchronously.
  assign busy       = data_valid | ((state_q == IDLE) & start & reset);

endmodule

// File: tb/tb_parallel_unloader.sv
module tb_parallel_unloader;

  typedef struct {
    logic [7:0] d;
    logic [3:0] i;
  } exp_t;

  logic         mclk;
  logic         reset;
  logic [119:0] bus_in;
  logic         start;
  logic [3:0]   len;
  logic [7:0]   data_out;
  logic         data_valid;
  logic         data_ready;
  logic [3:0]   byte_idx;
  logic         busy;
  logic         done;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   done_exp = 0;

  parallel_unloader dut (
    .mclk       (mclk),
    .reset      (reset),
    .bus_in     (bus_in),
    .start      (start),
    .len        (len),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .byte_idx   (byte_idx),
    .busy       (busy),
    .done       (done)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [119:0] bus, input int nbytes, input bit with_done);
    exp_t e;
    for (int k = 0; k < nbytes; k++) begin
      e.d = bus[8*k +: 8];
      e.i = 4'(k);
      exp_q.push_back(e);
    end
    if (with_done) done_exp++;
  endtask

  // Monitor: scoreboard pops on every transfer and every done pulse.
  logic       stall_prev = 1'b0;
  logic [7:0] prev_dat;
  logic [3:0] prev_idx;
  always @(negedge mclk) begin
    exp_t e;
    if (data_valid && data_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_byte: got %0h idx %0d expected none at %0t", data_out, byte_idx, $time);
      end else begin
        e = exp_q.pop_front();
        chk("byte_data", 32'(data_out), 32'(e.d));
        chk("byte_idx", 32'(byte_idx), 32'(e.i));
      end
    end
    if (stall_prev && data_valid) begin
      chk("stall_hold_data", 32'(data_out), 32'(prev_dat));
      chk("stall_hold_idx", 32'(byte_idx), 32'(prev_idx));
    end
    if (!data_valid) chk("idle_data_zero", 32'(data_out), 32'd0);
    stall_prev = data_valid && !data_ready;
    prev_dat   = data_out;
    prev_idx   = byte_idx;
    if (done) begin
      if (done_exp == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected 0 at %0t", $time);
      end else begin
        done_exp--;
      end
    end
  end

  // Runs one word from IDLE at posedge+1; returns in IDLE at posedge+1.
  task automatic run_word(input logic [119:0] bus, input logic [3:0] l, input bit toggle,
                          input bit restart, output int busy_n, output int done_at,
                          output int valid_n);
    bus_in  = bus;
    len     = l;
    start   = 1'b1;
    busy_n  = 0;
    valid_n = 0;
    done_at = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge mclk);
      if (busy) busy_n++;
      if (data_valid) valid_n++;
      if (done) begin
        done_at = c;
        break;
      end
      @(posedge mclk); #1;
      start  = restart && (c == 1);
      bus_in = start ? 120'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5 : ~bus;
      if (toggle) data_ready = ~data_ready;
    end
    if (done_at < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected done within 100 cycles");
    end
    @(posedge mclk); #1;
    start = 1'b0;
  endtask

  initial begin
    int           b, d, v;
    int           dcnt;
    int           dpos[3];
    logic [119:0] w;

    reset      = 1'b1;
    start      = 1'b0;
    bus_in     = '0;
    len        = '0;
    data_ready = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_idx", 32'(byte_idx), 32'd0);
    repeat (2) @(posedge mclk);
    #1 reset = 1'b1;
    @(posedge mclk); #1;

    // Full word, sink always ready.
    w = 120'h0E0D0C0B0A09080706050403020100;
    push_word(w, 15, 1'b1);
    run_word(w, 4'd15, 1'b0, 1'b0, b, d, v);
    chk("full_busy_cycles", 32'(b), 32'd16);
    chk("full_done_at", 32'(d), 32'd16);
    chk("full_valid_cycles", 32'(v), 32'd15);

    // Backpressure: ready toggles each cycle.
    data_ready = 1'b0;
    w = 120'h1122_3344_5566_7788_99AA_BBCC_DDEE_FF;
    push_word(w, 3, 1'b1);
    run_word(w, 4'd3, 1'b1, 1'b0, b, d, v);
    chk("bp_done_at", 32'(d), 32'd6);
    chk("bp_busy_cycles", 32'(b), 32'd6);
    data_ready = 1'b1;

    // len = 0: no bytes, done the cycle after start.
    push_word(w, 0, 1'b1);
    run_word(w, 4'd0, 1'b0, 1'b0, b, d, v);
    chk("len0_done_at", 32'(d), 32'd1);
    chk("len0_valid_cycles", 32'(v), 32'd0);
    chk("len0_busy_cycles", 32'(b), 32'd1);

    // len = 1: only the low byte.
    w = 120'h0102_0304_0506_0708_090A_0B0C_0D0E_5A;
    push_word(w, 1, 1'b1);
    run_word(w, 4'd1, 1'b0, 1'b0, b, d, v);
    chk("len1_done_at", 32'(d), 32'd2);

    // Start pulsed mid-SEND with a new word is ignored.
    w = 120'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DE;
    push_word(w, 4, 1'b1);
    run_word(w, 4'd4, 1'b0, 1'b1, b, d, v);
    chk("ign_done_at", 32'(d), 32'd5);
    repeat (3) @(posedge mclk);
    #1 chk("ign_no_second_word", 32'(data_valid), 32'd0);

    // Held start, len = 2: words every 4 cycles.
    w = 120'h0000_0000_0000_0000_0000_0000_00C3_3C;
    for (int k = 0; k < 3; k++) push_word(w, 2, 1'b1);
    bus_in = w;
    len    = 4'd2;
    start  = 1'b1;
    dcnt   = 0;
    for (int c = 0; c < 40 && dcnt < 3; c++) begin
      @(negedge mclk);
      if (done) begin
        dpos[dcnt] = c;
        dcnt++;
      end
      @(posedge mclk); #1;
      if (dcnt == 3) start = 1'b0;
    end
    start = 1'b0;
    chk("held_done_count", 32'(dcnt), 32'd3);
    chk("held_done0", 32'(dpos[0]), 32'd3);
    chk("held_done1", 32'(dpos[1]), 32'd7);
    chk("held_done2", 32'(dpos[2]), 32'd11);
    repeat (2) @(posedge mclk);
    #1;

    // Reset during byte 5 of 15.
    w = 120'hF0E0D0C0B0A090807060504030201F;
    push_word(w, 5, 1'b0);
    bus_in = w;
    len    = 4'd15;
    start  = 1'b1;
    @(posedge mclk); #1;
    start = 1'b0;
    repeat (5) @(posedge mclk);
    #1 chk("rst_mid_idx_before", 32'(byte_idx), 32'd5);
    #1 reset = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(data_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    repeat (2) @(posedge mclk);
    #1 reset = 1'b1;
    repeat (3) @(posedge mclk);
    #1;

    // Next word after the abort starts at byte 0.
    w = 120'h0E0D0C0B0A09080706050403020100;
    push_word(w, 15, 1'b1);
    run_word(w, 4'd15, 1'b0, 1'b0, b, d, v);
    chk("after_rst_done_at", 32'(d), 32'd16);

    repeat (3) @(posedge mclk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("done_pending", 32'(done_exp), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
